// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel between fetch (0) and dcache fill (1), 8-beat WRAP bursts.
// Define AXI_RD_ARB_ROUND_ROBIN_EN for round-robin ties; default gives requester 1 fixed priority.
module axi_rd_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_data,
    output logic                  resp0_last,
    output logic                  resp0_err,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_data,
    output logic                  resp1_last,
    output logic                  resp1_err,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_next;
    logic grant, last_grant, pick, accept, beat_fire, beat_err;
    logic [2:0] beat;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;

    assign pick = (req0_valid && req1_valid) ? (RR ? ~last_grant : 1'b1) : req1_valid;
    assign accept = reset && state == IDLE && (req0_valid || req1_valid);
    assign beat_fire = m_axi_rvalid && m_axi_rready;
    // A beat is bad if it errors, carries a foreign id, or rlast disagrees with the final-beat position.
    assign beat_err = (m_axi_rresp != 2'b00) || (m_axi_rid != m_axi_arid)
                    || (m_axi_rlast != (beat == 3'(BURST_LEN - 1)));

    assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, grant};
    assign m_axi_araddr  = addr & {{(ADDR_WIDTH-3){1'b1}}, 3'b000};
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'b011;
    assign m_axi_arburst = 2'b10;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign resp0_data    = data;
    assign resp1_data    = data;

    always_ff @(posedge clk) begin
        state <= !reset ? IDLE : state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (req0_valid || req1_valid) ? ADDR : IDLE;
            ADDR:    state_next = m_axi_arready ? DATA : ADDR;
            DATA:    state_next = (m_axi_rvalid && m_axi_rlast) ? IDLE : DATA;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready    = accept && !pick;
        req1_ready    = accept && pick;
        m_axi_arvalid = reset && state == ADDR;
        m_axi_rready  = reset && state == DATA;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            beat        <= '0;
            resp0_valid <= 1'b0;
            resp0_last  <= 1'b0;
            resp0_err   <= 1'b0;
            resp1_valid <= 1'b0;
            resp1_last  <= 1'b0;
            resp1_err   <= 1'b0;
        end else begin
            if (accept) begin
                grant      <= pick;
                last_grant <= pick;
                addr       <= pick ? req1_addr : req0_addr;
                beat       <= '0;
            end else if (beat_fire) begin
                beat <= m_axi_rlast ? 3'd0 : beat + 3'd1;
            end
            if (beat_fire) data <= m_axi_rdata;
            resp0_valid <= beat_fire && !grant;
            resp0_last  <= beat_fire && !grant && m_axi_rlast;
            resp0_err   <= beat_fire && !grant && beat_err;
            resp1_valid <= beat_fire && grant;
            resp1_last  <= beat_fire && grant && m_axi_rlast;
            resp1_err   <= beat_fire && grant && beat_err;
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: randomized bench with a transaction-level arbitration and beat-status model.
module tb_axi_rd_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req0_valid, req0_ready, resp0_valid, resp0_last, resp0_err;
    logic req1_valid, req1_ready, resp1_valid, resp1_last, resp1_err;
    logic [63:0] req0_addr, req1_addr, resp0_data, resp1_data;
    logic [12:0] m_axi_arid, m_axi_rid;
    logic [63:0] m_axi_araddr, m_axi_rdata;
    logic [7:0] m_axi_arlen;
    logic [2:0] m_axi_arsize, m_axi_arprot;
    logic [1:0] m_axi_arburst, m_axi_rresp;
    logic [3:0] m_axi_arcache;
    logic m_axi_arlock, m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;

    axi_rd_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_last(resp0_last), .resp0_err(resp0_err),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_last(resp1_last), .resp1_err(resp1_err),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    bit lg_m = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Arbitration rule: lone requester wins; ties go by policy.
    function automatic bit model_pick(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
            return !lg_m;
`else
            return 1'b1;
`endif
        end
        return v1;
    endfunction

    task automatic issue(input bit v0, input logic [63:0] a0, input bit v1, input logic [63:0] a1,
                         input int ar_wait, output bit g);
        logic [63:0] a;
        g = model_pick(v0, v1);
        a = g ? a1 : a0;
        req0_valid = v0; req0_addr = a0; req1_valid = v1; req1_addr = a1;
        #1;
        check("req0_ready", req0_ready, !g);
        check("req1_ready", req1_ready, g);
        lg_m = g;
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        #1;
        check("arvalid", m_axi_arvalid, 1);
        check("araddr", m_axi_araddr, a & ~64'h7);
        check("arid", m_axi_arid, 64'(g));
        check("arlen", m_axi_arlen, 7);
        check("arsize", m_axi_arsize, 3);
        check("arburst", m_axi_arburst, 2);
        check("arcache", m_axi_arcache, 3);
        check("arlock_prot", {m_axi_arlock, m_axi_arprot}, 0);
        check("rready_addr", m_axi_rready, 0);
        repeat (ar_wait) begin
            req0_valid = 1; req1_valid = 1;
            @(negedge clk);
            #1;
            check("arvalid_hold", m_axi_arvalid, 1);
            check("araddr_hold", m_axi_araddr, a & ~64'h7);
            check("req_blocked", {req0_ready, req1_ready}, 0);
        end
        req0_valid = 0; req1_valid = 0;
        m_axi_arready = 1;
        @(negedge clk);
        m_axi_arready = 0;
        #1;
        check("arvalid_drop", m_axi_arvalid, 0);
        check("rready_data", m_axi_rready, 1);
    endtask

    task automatic r_cycle(input bit g, input bit v, input logic [1:0] rs, input logic [12:0] id,
                           input bit last, input int idx);
        logic [63:0] d;
        bit e;
        d = {$urandom, $urandom};
        m_axi_rvalid = v; m_axi_rdata = d; m_axi_rresp = rs; m_axi_rid = id; m_axi_rlast = last;
        e = (rs != 0) || (id != 13'(g)) || (last && idx % 8 != 7) || (!last && idx % 8 == 7);
        #1 check("rready", m_axi_rready, 1);
        @(negedge clk);
        m_axi_rvalid = 0; m_axi_rlast = 0;
        #1;
        check("resp0_valid", resp0_valid, v && !g);
        check("resp1_valid", resp1_valid, v && g);
        if (v) begin
            check("resp_data", g ? resp1_data : resp0_data, d);
            check("resp_last", g ? resp1_last : resp0_last, last);
            check("resp_err", g ? resp1_err : resp0_err, e);
        end
    endtask

    task automatic beats(input bit g, input int last_at, input int bad_at, input bit rnd);
        for (int i = 0; i <= last_at; i++) begin
            logic [1:0] rs;
            logic [12:0] id;
            if (rnd && $urandom_range(0, 3) == 0) r_cycle(g, 0, 0, 0, 0, i);
            rs = (i == bad_at) ? 2'b10 : (rnd && $urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            id = (rnd && $urandom_range(0, 15) == 0) ? 13'h155 : 13'(g);
            r_cycle(g, 1, rs, id, i == last_at, i);
        end
        check("idle_rready", m_axi_rready, 0);
        check("idle_arvalid", m_axi_arvalid, 0);
    endtask

    initial begin
        bit g, v0, v1;
        req0_valid = 1; req1_valid = 0; req0_addr = 0; req1_addr = 0;
        m_axi_arready = 0; m_axi_rid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0; m_axi_rvalid = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_req_ready", {req0_ready, req1_ready}, 0);
        check("rst_resp", {resp0_valid, resp0_last, resp0_err, resp1_valid, resp1_last, resp1_err}, 0);
        req0_valid = 0; reset = 1;
        @(negedge clk);
        issue(1, 64'h8000_0004, 0, 64'h0, 0, g);
        beats(g, 7, -1, 0);
        issue(1, 64'h1000, 1, 64'h2000, 0, g);
        beats(g, 7, -1, 0);
        issue(g, 64'h1000, !g, 64'h2000, 0, g);
        beats(g, 7, -1, 0);
        issue(0, 64'h0, 1, 64'h3008, 5, g);
        beats(g, 7, -1, 0);
        issue(1, 64'h4000, 0, 64'h0, 0, g);
        beats(g, 7, 2, 0);
        issue(0, 64'h0, 1, 64'h5000, 0, g);
        beats(g, 4, -1, 0);
        issue(1, 64'h6000, 0, 64'h0, 0, g);
        for (int i = 0; i < 3; i++) r_cycle(g, 1, 0, 13'(g), 0, i);
        reset = 0; req0_valid = 1;
        m_axi_rvalid = 1; m_axi_rid = 13'(g); m_axi_rresp = 0;
        #1;
        check("rstmid_rready", m_axi_rready, 0);
        check("rstmid_req_ready", req0_ready, 0);
        @(negedge clk);
        m_axi_rvalid = 0;
        #1;
        check("rstmid_resp", {resp0_valid, resp1_valid}, 0);
        check("rstmid_rready2", m_axi_rready, 0);
        check("rstmid_arvalid", m_axi_arvalid, 0);
        req0_valid = 0; reset = 1; lg_m = 1;
        @(negedge clk);
        issue(1, 64'h7000, 0, 64'h0, 0, g);
        beats(g, 7, -1, 0);
        repeat (25) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            issue(v0, {$urandom, $urandom}, v1, {$urandom, $urandom}, $urandom_range(0, 3), g);
            beats(g, ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : 7, -1, 1);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Shares the single AXI read-address/read-data channel pair between two burst requesters: requester 0 is instruction fetch and requester 1 is data cache line fill. It accepts one line-fill request at a time and issues an 8-beat, 64-bit WRAP burst on AR. It then steers the returning R beats, registered, to the granted requester. It sits between the core's fetch/cache front ends and the top-level m_axi_ar*/m_axi_r* ports.

Parameters:
ID_WIDTH, 13, width of ARID/RID
ADDR_WIDTH, 64, request and AR address width
DATA_WIDTH, 64, R data width; ARSIZE is fixed at 3'b011 for 64 bits
BURST_LEN, 8, beats per burst; ARLEN = BURST_LEN-1

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-low reset
req0_valid  in  1  fetch request valid
req0_addr  in  ADDR_WIDTH  fetch line address
req0_ready  out  1  fetch request accepted this cycle
resp0_valid  out  1  fetch data beat valid
resp0_data  out  DATA_WIDTH  fetch data beat
resp0_last  out  1  final beat of the fetch burst
resp0_err  out  1  beat carries an error
req1_valid, req1_addr, req1_ready, resp1_valid, resp1_data, resp1_last, resp1_err  same as above, for the data cache
m_axi_arid  out  ID_WIDTH  {0..., grant index}
m_axi_araddr  out  ADDR_WIDTH  request address with bits [2:0] cleared
m_axi_arlen  out  8  BURST_LEN-1
m_axi_arsize  out  3  3'b011
m_axi_arburst  out  2  2'b10 (WRAP)
m_axi_arlock  out  1  0
m_axi_arcache  out  4  4'b0011
m_axi_arprot  out  3  3'b000
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address accepted
m_axi_rid  in  ID_WIDTH  response id
m_axi_rdata  in  DATA_WIDTH  response data
m_axi_rresp  in  2  response status
m_axi_rlast  in  1  last beat
m_axi_rvalid  in  1  beat valid
m_axi_rready  out  1  beat accepted

Behaviour:
- States: IDLE, ADDR, DATA. Reset (reset==0 at posedge) forces IDLE from any state, including mid-burst.
- Registers cleared on reset: grant, beat counter, last_grant=1, all resp*_valid/last/err. Outputs during reset: arvalid=0, rready=0, req*_ready=0.
- IDLE:
  - req_ready is combinational and asserted only for the granted requester when at least one reqN_valid is high.
  - On accept, latch the address and grant, then go to ADDR on the next cycle.
  - No grant is made while any request is outstanding. At most one burst is in flight.
- ADDR:
  - arvalid=1. araddr, arid and the fixed AR fields are driven from registers and held stable until arready.
  - The cycle after arvalid&arready, go to DATA. arvalid deasserts in that same cycle.
- DATA:
  - rready=1 unconditionally; requesters cannot backpressure.
  - Each rvalid beat is registered. The following cycle, the granted resp port shows valid=1 with data=rdata and last=rlast. err is set if rresp!=0, or rid!=arid, or rlast arrives on a beat other than BURST_LEN-1, or beat BURST_LEN-1 arrives without rlast.
  - The beat counter is 3 bits and wraps, but a burst always terminates on rlast.
  - On rlast, go to IDLE. A new grant is possible in the same cycle the last beat appears on resp.
- The non-granted resp port stays valid=0. resp*_valid is a single-cycle pulse per beat.
- Fetch-to-first-AR latency: accept at cycle N, arvalid at N+1.
- Beat latency: R beat at cycle M appears on resp at M+1.
- Simultaneous requests: arbitration policy is set by the optional feature below. last_grant is updated on every accept.

Optional Feature:
- Macro: AXI_RD_ARB_ROUND_ROBIN_EN.
- Defined: when both requests are valid, grant the requester not equal to last_grant; a single valid requester is always granted.
- Undefined: fixed priority, requester 1 (dcache) always wins ties; last_grant is still maintained but unused.

Test Plan:
- Single fetch, req0_addr=0x80000004, arready at once, 8 beats with rid=0 and rresp=0 -> araddr=0x80000000, arlen=7, arburst=2, arid=0; resp0 shows 8 valid pulses, each one cycle after its R beat, last only on beat 8; resp1 stays silent.
- req0 and req1 valid in the same cycle, addresses 0x1000 and 0x2000 -> without the macro: 0x2000 issued first, then 0x1000. With the macro, after reset (last_grant=1): 0x1000 first, then 0x2000.
- arready held low for 5 cycles -> arvalid stays 1 with a stable araddr; DATA is entered only after the handshake.
- rresp=2'b10 on beat 3 -> resp_err=1 on beat 3 only; the burst still completes on rlast.
- rlast on beat 5 -> err=1 and last=1 on that beat; FSM returns to IDLE.
- reset=0 during beat 4 of a burst -> next cycle IDLE, all valids 0, rready=0; a new request is granted normally after reset=1.
